// File: rtl/usr_seq_ctrl_if.sv
// Command and shift-register bus between usr_seq_ctrl and its environment.
// The slave modport is the controller's view; master is the command/register side.
interface usr_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_dir;
  logic [CNT_W-1:0] cmd_count;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_fill;
  logic [1:0]       sel;
  logic [WIDTH-1:0] p_in;
  logic             s_right;
  logic             s_left;
  logic [WIDTH-1:0] q_in;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             busy;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_count, cmd_data, cmd_fill, q_in,
    output cmd_ready, sel, p_in, s_right, s_left, result, done, busy
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_count, cmd_data, cmd_fill, q_in,
    input  cmd_ready, sel, p_in, s_right, s_left, result, done, busy
  );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequencer for a universal shift register: parallel load, N shift cycles,
// then capture of the register contents with a one-cycle done pulse.
module usr_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input logic             clk,
  input logic             rest_n,
  usr_seq_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_count;
  logic             lat_dir;
  logic             lat_fill;

  // Outputs are registered from the next state, so they track the state
  // in the same cycle; p_in itself holds the latched data word during LOAD.
  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state         <= IDLE;
      cnt           <= '0;
      lat_count     <= '0;
      lat_dir       <= 1'b0;
      lat_fill      <= 1'b0;
      bus.cmd_ready <= 1'b1;
      bus.sel       <= SEL_HOLD;
      bus.p_in      <= '0;
      bus.s_right   <= 1'b0;
      bus.s_left    <= 1'b0;
      bus.result    <= '0;
      bus.done      <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            lat_dir       <= bus.cmd_dir;
            lat_count     <= bus.cmd_count;
            lat_fill      <= bus.cmd_fill;
            bus.p_in      <= bus.cmd_data;
            bus.sel       <= SEL_LOAD;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= LOAD;
          end
        end

        LOAD: begin
          bus.p_in <= '0;
          if (lat_count == '0) begin
            bus.sel <= SEL_HOLD;
            state   <= CAPTURE;
          end else begin
            cnt         <= lat_count;
            bus.sel     <= lat_dir ? SEL_LEFT : SEL_RIGHT;
            bus.s_right <= ~lat_dir & lat_fill;
            bus.s_left  <= lat_dir & lat_fill;
            state       <= SHIFT;
          end
        end

        SHIFT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bus.sel     <= SEL_HOLD;
            bus.s_right <= 1'b0;
            bus.s_left  <= 1'b0;
            state       <= CAPTURE;
          end
        end

        CAPTURE: begin
          bus.result    <= bus.q_in;
          bus.done      <= 1'b1;
          bus.busy      <= 1'b0;
          bus.cmd_ready <= 1'b1;
          state         <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
